// File: rtl/io_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_bus_arbiter
// Purpose  : Shares one peripheral IO bus between the J1 CPU and two
//            secondary masters. The CPU always wins the bus combinationally,
//            with no wait state. The masters are served through a three-state
//            FSM (IDLE -> ISSUE -> CAPTURE) that slips into CPU-idle cycles.
// Ports    : clk, rst (async, active-low)
//            cpu_addr/cpu_dout/cpu_rd/cpu_wr in, cpu_din out (= p_din)
//            mN_req/mN_rd/mN_addr/mN_wdata in, mN_ack/mN_rdata out (N=1,2)
//            p_addr/p_dout/p_rd/p_wr out, p_din in (shared peripheral bus)
//            busy out (FSM not in IDLE)
// Config   : IO_ARB_RR_EN defined   -> round-robin between M1 and M2
//            IO_ARB_RR_EN undefined -> fixed priority, M1 over M2
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] cpu_din,
    input  logic        m1_req,
    input  logic        m1_rd,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    input  logic        m2_req,
    input  logic        m2_rd,
    input  logic [15:0] m2_addr,
    input  logic [15:0] m2_wdata,
    output logic        m2_ack,
    output logic [15:0] m2_rdata,
    output logic [15:0] p_addr,
    output logic [15:0] p_dout,
    output logic        p_rd,
    output logic        p_wr,
    input  logic [15:0] p_din,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] C_GNT_NONE = 2'd0;
    localparam logic [1:0] C_GNT_M1   = 2'd1;
    localparam logic [1:0] C_GNT_M2   = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        w_cpu_act;
    logic        w_pick_m2;
    logic        w_issue;
    logic        w_capture;

    // Request fields of the granted master; masters hold them until ack.
    logic        w_g_req;
    logic        w_g_rd;
    logic [15:0] w_g_addr;
    logic [15:0] w_g_wdata;

    assign w_cpu_act = cpu_rd | cpu_wr;
    assign cpu_din   = p_din;
    assign busy      = (r_state != ST_IDLE);
    assign w_capture = (r_state == ST_CAPTURE);

    always_comb begin
        w_g_req   = 1'b0;
        w_g_rd    = m1_rd;
        w_g_addr  = m1_addr;
        w_g_wdata = m1_wdata;
        if (r_grant == C_GNT_M1) begin
            w_g_req = m1_req;
        end else if (r_grant == C_GNT_M2) begin
            w_g_req   = m2_req;
            w_g_rd    = m2_rd;
            w_g_addr  = m2_addr;
            w_g_wdata = m2_wdata;
        end
    end

`ifdef IO_ARB_RR_EN
    // r_rr_m2 = 1 means M2 wins the next simultaneous request.
    logic r_rr_m2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_m2 <= 1'b0;
        end else if (w_capture) begin
            r_rr_m2 <= (r_grant == C_GNT_M1);
        end
    end

    assign w_pick_m2 = m2_req & (~m1_req | r_rr_m2);
`else
    assign w_pick_m2 = m2_req & ~m1_req;
`endif

    // A master cycle goes out only when the CPU leaves the bus free and the
    // granted master is still requesting.
    assign w_issue = (r_state == ST_ISSUE) & ~w_cpu_act & w_g_req;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (m1_req | m2_req) begin
                    w_grant_nxt = w_pick_m2 ? C_GNT_M2 : C_GNT_M1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A withdrawn request aborts even if the CPU holds the bus.
                if (!w_g_req) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = C_GNT_NONE;
                end else if (!w_cpu_act) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = C_GNT_NONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = C_GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= C_GNT_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Ack and read data are registered together so the master sees them in
    // the same cycle, three cycles after its request when the CPU is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1_ack   <= 1'b0;
            m2_ack   <= 1'b0;
            m1_rdata <= 16'h0000;
            m2_rdata <= 16'h0000;
        end else begin
            m1_ack <= w_capture & (r_grant == C_GNT_M1);
            m2_ack <= w_capture & (r_grant == C_GNT_M2);
            if (w_capture && w_g_rd && (r_grant == C_GNT_M1)) begin
                m1_rdata <= p_din;
            end
            if (w_capture && w_g_rd && (r_grant == C_GNT_M2)) begin
                m2_rdata <= p_din;
            end
        end
    end

    always_comb begin
        p_addr = 16'h0000;
        p_dout = 16'h0000;
        p_rd   = 1'b0;
        p_wr   = 1'b0;
        if (w_cpu_act) begin
            p_addr = cpu_addr;
            p_dout = cpu_dout;
            p_rd   = cpu_rd;
            p_wr   = cpu_wr;
        end else if (w_issue) begin
            p_addr = w_g_addr;
            p_dout = w_g_wdata;
            p_rd   = w_g_rd;
            p_wr   = ~w_g_rd;
        end
    end

endmodule
`default_nettype wire
